// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response bundle of the SRAM bus controller.
// The controller takes the slave view; the CPU (or a bench) takes the master view.
interface mem_bus_ctrl_if;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        ram_re_i;
    logic        ram_we_i;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic [3:0]  ram_mask_i;
    logic [31:0] ram_data_o;
    logic        stallreq_o;

    modport master (
        output rom_ce_i, rom_addr_i, ram_re_i, ram_we_i, ram_addr_i, ram_data_i, ram_mask_i,
        input  rom_data_o, ram_data_o, stallreq_o
    );

    modport slave (
        input  rom_ce_i, rom_addr_i, ram_re_i, ram_we_i, ram_addr_i, ram_data_i, ram_mask_i,
        output rom_data_o, ram_data_o, stallreq_o
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-port SRAM controller arbitrating CPU data and instruction accesses.
// Data access goes first; a pending fetch follows it before the pipeline is released.
module mem_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_bus_ctrl_if.slave cpu,
    output logic [19:0]   sram_addr_o,
    output logic [31:0]   sram_data_o,
    output logic          sram_data_oe_o,
    input  logic [31:0]   sram_data_i,
    output logic          sram_ce_n_o,
    output logic          sram_oe_n_o,
    output logic          sram_we_n_o,
    output logic [3:0]    sram_be_n_o
);

    typedef enum logic [1:0] {
        IDLE,
        DATA_ACC,
        INST_ACC,
        DONE
    } state_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [31:0] data;
        logic        data_oe;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic [3:0]  be_n;
    } sram_drv_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    function automatic sram_drv_t drv_idle();
        sram_drv_t d;
        d.addr    = '0;
        d.data    = '0;
        d.data_oe = 1'b0;
        d.ce_n    = 1'b1;
        d.oe_n    = 1'b1;
        d.we_n    = 1'b1;
        d.be_n    = '1;
        return d;
    endfunction

    function automatic sram_drv_t drv_read(input logic [31:0] byte_addr);
        sram_drv_t d;
        d.addr    = byte_addr[21:2];
        d.data    = '0;
        d.data_oe = 1'b0;
        d.ce_n    = 1'b0;
        d.oe_n    = 1'b0;
        d.we_n    = 1'b1;
        d.be_n    = '0;
        return d;
    endfunction

    // WAIT_CYCLES >= 2, so the first write cycle is never the last one.
    function automatic sram_drv_t drv_write(input logic [31:0] byte_addr,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  mask);
        sram_drv_t d;
        d.addr    = byte_addr[21:2];
        d.data    = wdata;
        d.data_oe = 1'b1;
        d.ce_n    = 1'b0;
        d.oe_n    = 1'b1;
        d.we_n    = 1'b0;
        d.be_n    = ~mask;
        return d;
    endfunction

    state_t      state;
    logic [3:0]  cnt;
    logic        acc_write;
    sram_drv_t   drv;
    logic [31:0] rom_data_q;
    logic [31:0] ram_data_q;
    logic        data_req;
    logic        stall;

    assign data_req = cpu.ram_re_i | cpu.ram_we_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc_write  <= 1'b0;
            drv        <= drv_idle();
            rom_data_q <= '0;
            ram_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_req) begin
                        state     <= DATA_ACC;
                        cnt       <= CNT_LOAD;
                        acc_write <= cpu.ram_we_i;
                        drv       <= cpu.ram_we_i
                                     ? drv_write(cpu.ram_addr_i, cpu.ram_data_i, cpu.ram_mask_i)
                                     : drv_read(cpu.ram_addr_i);
                    end else if (cpu.rom_ce_i) begin
                        state <= INST_ACC;
                        cnt   <= CNT_LOAD;
                        drv   <= drv_read(cpu.rom_addr_i);
                    end
                end
                DATA_ACC: begin
                    if (cnt == '0) begin
                        if (!acc_write)
                            ram_data_q <= sram_data_i;
                        if (cpu.rom_ce_i) begin
                            state <= INST_ACC;
                            cnt   <= CNT_LOAD;
                            drv   <= drv_read(cpu.rom_addr_i);
                        end else begin
                            state <= DONE;
                            drv   <= drv_idle();
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                        // Release WE one cycle early so address/data are held past its rising edge.
                        if (cnt == 4'd1)
                            drv.we_n <= 1'b1;
                    end
                end
                INST_ACC: begin
                    if (cnt == '0) begin
                        rom_data_q <= sram_data_i;
                        state      <= DONE;
                        drv        <= drv_idle();
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    drv   <= drv_idle();
                end
            endcase
        end
    end

    // The IDLE term must be combinational so the CPU stalls in the very cycle it asks.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:     stall = data_req | cpu.rom_ce_i;
                DATA_ACC: stall = 1'b1;
                INST_ACC: stall = 1'b1;
                default:  stall = 1'b0;
            endcase
        end
    end

    assign cpu.stallreq_o = stall;
    assign cpu.rom_data_o = rom_data_q;
    assign cpu.ram_data_o = ram_data_q;

    assign sram_addr_o    = drv.addr;
    assign sram_data_o    = drv.data;
    assign sram_data_oe_o = drv.data_oe;
    assign sram_ce_n_o    = drv.ce_n;
    assign sram_oe_n_o    = drv.oe_n;
    assign sram_we_n_o    = drv.we_n;
    assign sram_be_n_o    = drv.be_n;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: a WAIT_CYCLES=2 and a WAIT_CYCLES=4 instance against a
// request-timeline model, plus hand-computed literals for the directed scenarios.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          sel;
    logic        rom_ce, re, we;
    logic [31:0] rom_addr, raddr, wdata;
    logic [3:0]  mask;

    mem_bus_ctrl_if b2();
    mem_bus_ctrl_if b4();

    assign b2.rom_ce_i   = (sel == 2) && rom_ce;
    assign b2.ram_re_i   = (sel == 2) && re;
    assign b2.ram_we_i   = (sel == 2) && we;
    assign b2.rom_addr_i = rom_addr;
    assign b2.ram_addr_i = raddr;
    assign b2.ram_data_i = wdata;
    assign b2.ram_mask_i = mask;
    assign b4.rom_ce_i   = (sel == 4) && rom_ce;
    assign b4.ram_re_i   = (sel == 4) && re;
    assign b4.ram_we_i   = (sel == 4) && we;
    assign b4.rom_addr_i = rom_addr;
    assign b4.ram_addr_i = raddr;
    assign b4.ram_data_i = wdata;
    assign b4.ram_mask_i = mask;

    logic [19:0] s2_addr, s4_addr;
    logic [31:0] s2_wdata, s4_wdata, s2_rdata, s4_rdata;
    logic        s2_doe, s4_doe, s2_ce_n, s4_ce_n, s2_oe_n, s4_oe_n, s2_we_n, s4_we_n;
    logic [3:0]  s2_be_n, s4_be_n;

    // SRAM contents: two pinned words, everything else tagged with its own address.
    function automatic logic [31:0] sram_word(input logic [19:0] a);
        if (a == 20'h00004) return 32'h24020005;
        if (a == 20'h00041) return 32'h12345678;
        return {12'hC3A, a};
    endfunction

    assign s2_rdata = sram_word(s2_addr);
    assign s4_rdata = sram_word(s4_addr);

    mem_bus_ctrl #(.WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .cpu(b2.slave),
        .sram_addr_o(s2_addr), .sram_data_o(s2_wdata), .sram_data_oe_o(s2_doe),
        .sram_data_i(s2_rdata), .sram_ce_n_o(s2_ce_n), .sram_oe_n_o(s2_oe_n),
        .sram_we_n_o(s2_we_n), .sram_be_n_o(s2_be_n)
    );

    mem_bus_ctrl #(.WAIT_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .cpu(b4.slave),
        .sram_addr_o(s4_addr), .sram_data_o(s4_wdata), .sram_data_oe_o(s4_doe),
        .sram_data_i(s4_rdata), .sram_ce_n_o(s4_ce_n), .sram_oe_n_o(s4_oe_n),
        .sram_we_n_o(s4_we_n), .sram_be_n_o(s4_be_n)
    );

    typedef struct packed {
        logic        stall;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic        data_oe;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic [3:0]  be_n;
    } bus_t;

    bus_t act2, act4, obs;
    assign act2 = {b2.stallreq_o, s2_addr, s2_wdata, s2_doe, s2_ce_n, s2_oe_n, s2_we_n, s2_be_n};
    assign act4 = {b4.stallreq_o, s4_addr, s4_wdata, s4_doe, s4_ce_n, s4_oe_n, s4_we_n, s4_be_n};
    assign obs  = (sel == 2) ? act2 : act4;

    int          n_vec = 0;
    int          n_err = 0;
    int          k;
    logic [31:0] held_rom [0:1];
    logic [31:0] held_ram [0:1];

    // Model: k counts cycles since the request appeared in IDLE. Cycle 0 is that IDLE
    // cycle, then W data cycles (if any), W fetch cycles (if any), then one DONE cycle.
    function automatic bus_t model_bus(input int w, input bit on, input int kk);
        bus_t e;
        int   nd, total;
        e = '{stall: 1'b0, addr: '0, wdata: '0, data_oe: 1'b0, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, be_n: 4'hF};
        if (!on || !(re || we || rom_ce)) return e;
        nd    = (re || we) ? w : 0;
        total = nd + (rom_ce ? w : 0);
        if (kk <= total) e.stall = 1'b1;
        if (kk >= 1 && kk <= nd) begin
            e.ce_n = 1'b0;
            e.addr = raddr[21:2];
            if (we) begin
                e.wdata   = wdata;
                e.data_oe = 1'b1;
                e.be_n    = ~mask;
                e.we_n    = (kk == nd);
            end else begin
                e.oe_n = 1'b0;
                e.be_n = 4'h0;
            end
        end else if (kk > nd && kk <= total) begin
            e.ce_n = 1'b0;
            e.oe_n = 1'b0;
            e.be_n = 4'h0;
            e.addr = rom_addr[21:2];
        end
        return e;
    endfunction

    function automatic logic [31:0] model_ram(input int w, input bit on, input int kk, input int i);
        if (on && re && !we && kk > w) return sram_word(raddr[21:2]);
        return held_ram[i];
    endfunction

    function automatic logic [31:0] model_rom(input int w, input bit on, input int kk, input int i);
        int total;
        total = ((re || we) ? w : 0) + w;
        if (on && rom_ce && kk > total) return sram_word(rom_addr[21:2]);
        return held_rom[i];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input string tag, input int w, input bit on, input bus_t a,
                              input logic [31:0] ram_a, input logic [31:0] rom_a, input int i);
        bus_t e;
        e = model_bus(w, on, k);
        chk({tag, ".stallreq_o"},     32'(a.stall),   32'(e.stall));
        chk({tag, ".sram_ce_n_o"},    32'(a.ce_n),    32'(e.ce_n));
        chk({tag, ".sram_oe_n_o"},    32'(a.oe_n),    32'(e.oe_n));
        chk({tag, ".sram_we_n_o"},    32'(a.we_n),    32'(e.we_n));
        chk({tag, ".sram_be_n_o"},    32'(a.be_n),    32'(e.be_n));
        chk({tag, ".sram_data_oe_o"}, 32'(a.data_oe), 32'(e.data_oe));
        chk({tag, ".sram_addr_o"},    32'(a.addr),    32'(e.addr));
        chk({tag, ".sram_data_o"},    a.wdata,        e.wdata);
        chk({tag, ".ram_data_o"},     ram_a,          model_ram(w, on, k, i));
        chk({tag, ".rom_data_o"},     rom_a,          model_rom(w, on, k, i));
    endtask

    task automatic check_cycle();
        check_inst("u2", 2, sel == 2, act2, b2.ram_data_o, b2.rom_data_o, 0);
        check_inst("u4", 4, sel == 4, act4, b4.ram_data_o, b4.rom_data_o, 1);
    endtask

    task automatic clear_req();
        rom_ce = 1'b0; re = 1'b0; we = 1'b0;
        rom_addr = '0; raddr = '0; wdata = '0; mask = '0;
    endtask

    task automatic commit(input int w);
        int i;
        i = (sel == 2) ? 0 : 1;
        held_ram[i] = model_ram(w, 1'b1, 1000, i);
        held_rom[i] = model_rom(w, 1'b1, 1000, i);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        clear_req();
        k = 0;
        @(negedge clk); check_cycle();
    endtask

    // Requests must already be applied (posedge + 1) when this is called.
    task automatic run(input int w, output int stall_n, output int we_low,
                       output logic [19:0] addr1, output logic [3:0] be1);
        int total;
        total   = ((re || we) ? w : 0) + (rom_ce ? w : 0);
        stall_n = 0; we_low = 0; addr1 = '0; be1 = '0;
        for (int kk = 0; kk <= total + 1; kk++) begin
            if (kk > 0) begin @(posedge clk); #1; end
            k = kk;
            @(negedge clk); check_cycle();
            if (obs.stall) stall_n++;
            if (!obs.we_n) we_low++;
            if (kk == 1) begin addr1 = obs.addr; be1 = obs.be_n; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          st, wl;
        logic [19:0] a1;
        logic [3:0]  be1;

        rst = 1'b1; sel = 2; k = 0;
        clear_req();
        for (int i = 0; i < 2; i++) begin held_rom[i] = '0; held_ram[i] = '0; end

        // Reset state, with a request already pending to prove stall is gated.
        @(negedge clk); check_cycle();
        chk("reset.ce_n", 32'(s2_ce_n), 32'd1);
        chk("reset.be_n", 32'(s2_be_n), 32'hF);
        @(posedge clk); #1 rom_ce = 1'b1;
        @(negedge clk);
        chk("reset.stall_gated", 32'(b2.stallreq_o), 32'd0);
        chk("reset.rom_data",    b2.rom_data_o,      32'h0);
        @(posedge clk); #1 rst = 1'b0; clear_req();
        @(negedge clk); check_cycle();

        // Fetch only.
        @(posedge clk); #1;
        rom_ce = 1'b1; rom_addr = 32'h8000_0010;
        run(2, st, wl, a1, be1);
        chk("fetch.stall_cycles", 32'(st), 32'd3);
        chk("fetch.sram_addr",    32'(a1), 32'h00004);
        chk("fetch.rom_data",     b2.rom_data_o, 32'h2402_0005);
        commit(2); idle_cycle();

        // Write followed by fetch.
        @(posedge clk); #1;
        we = 1'b1; raddr = 32'h8000_0100; wdata = 32'hDEAD_BEEF; mask = 4'b0011;
        rom_ce = 1'b1; rom_addr = 32'h8000_0010;
        run(2, st, wl, a1, be1);
        chk("wrf.stall_cycles", 32'(st),  32'd5);
        chk("wrf.be_n",         32'(be1), 32'hC);
        chk("wrf.we_low",       32'(wl),  32'd1);
        chk("wrf.sram_addr",    32'(a1),  32'h00040);
        commit(2); idle_cycle();

        // Data read only.
        @(posedge clk); #1;
        re = 1'b1; raddr = 32'h8000_0104;
        run(2, st, wl, a1, be1);
        chk("rd.ram_data", b2.ram_data_o, 32'h1234_5678);
        chk("rd.rom_held", b2.rom_data_o, 32'h2402_0005);
        chk("rd.stall",    32'(st),       32'd3);
        commit(2); idle_cycle();

        // Read and write together: write wins, read data held.
        @(posedge clk); #1;
        re = 1'b1; we = 1'b1; raddr = 32'h8000_0200; wdata = 32'h0BAD_F00D; mask = 4'b1111;
        run(2, st, wl, a1, be1);
        chk("rw.we_low",   32'(wl),       32'd1);
        chk("rw.be_n",     32'(be1),      32'h0);
        chk("rw.ram_held", b2.ram_data_o, 32'h1234_5678);
        commit(2); idle_cycle();

        // Read then fetch, with address bits outside [21:2] set.
        @(posedge clk); #1;
        re = 1'b1; raddr = 32'h8000_0303; rom_ce = 1'b1; rom_addr = 32'hFFC0_0008;
        run(2, st, wl, a1, be1);
        chk("rdf.stall_cycles", 32'(st),       32'd5);
        chk("rdf.sram_addr",    32'(a1),       32'h000C0);
        chk("rdf.ram_data",     b2.ram_data_o, 32'hC3A0_00C0);
        chk("rdf.rom_data",     b2.rom_data_o, 32'hC3A0_0002);
        commit(2); idle_cycle();

        // Reset asserted in the first write cycle.
        @(posedge clk); #1;
        we = 1'b1; raddr = 32'h8000_0400; wdata = 32'h55AA_55AA; mask = 4'b1111; k = 0;
        @(negedge clk); check_cycle();
        @(posedge clk); #1 k = 1;
        @(negedge clk); check_cycle();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid.we_n",     32'(s2_we_n),        32'd1);
        chk("rst_mid.ce_n",     32'(s2_ce_n),        32'd1);
        chk("rst_mid.stall",    32'(b2.stallreq_o),  32'd0);
        chk("rst_mid.ram_data", b2.ram_data_o,       32'h0);
        chk("rst_mid.rom_data", b2.rom_data_o,       32'h0);
        clear_req();
        for (int i = 0; i < 2; i++) begin held_rom[i] = '0; held_ram[i] = '0; end
        @(posedge clk); #1 rst = 1'b0; k = 0;
        @(negedge clk); check_cycle();
        idle_cycle();

        // Back-to-back fetches on the WAIT_CYCLES=4 instance.
        @(posedge clk); #1;
        sel = 4; rom_ce = 1'b1; rom_addr = 32'h0000_0040;
        run(4, st, wl, a1, be1);
        chk("b2b0.stall_cycles", 32'(st), 32'd5);
        chk("b2b0.sram_addr",    32'(a1), 32'h00010);
        commit(4);
        @(posedge clk); #1;
        rom_addr = 32'h0000_0044;
        run(4, st, wl, a1, be1);
        chk("b2b1.stall_cycles", 32'(st),       32'd5);
        chk("b2b1.sram_addr",    32'(a1),       32'h00011);
        chk("b2b1.rom_data",     b4.rom_data_o, 32'hC3A0_0011);
        commit(4); idle_cycle();
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
